// File: rtl/game_phase_sequencer.sv
// Game phase sequencer: IDLE -> ARM -> PLAY -> OVER, with LED frame selection and game-clear pulse.
// Optional BLINK_GAMEOVER_EN blinks the frozen game-over frame every BLINK_TICKS ticks.
module game_phase_sequencer #(
  parameter int unsigned HOLD_TICKS  = 8,
  parameter int unsigned BLINK_TICKS = 4
) (
  input  logic              CLK,
  input  logic              NOT_RST,
  input  logic              STARTen,
  input  logic              TICK,
  input  logic              KEY_START,
  input  logic              COLLIDE,
  input  logic [15:0][15:0] PixRST,
  input  logic [15:0][15:0] PixGAME,
  output logic [15:0][15:0] PixOUT,
  output logic              GAMEen,
  output logic              GAMECLR,
  output logic [1:0]        PHASE
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    PLAY = 2'b10,
    OVER = 2'b11
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

  // Elaboration-time range guard on the configuration.
  if (HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_hold
    $error("HOLD_TICKS out of range 1..255");
  end
  if (BLINK_TICKS < 1 || BLINK_TICKS > 255) begin : g_bad_blink
    $error("BLINK_TICKS out of range 1..255");
  end

  state_e            state_q, state_d;
  logic              key_prev_q;
  logic              key_edge;
  logic [7:0]        tick_cnt_q;
  logic [15:0][15:0] snap_q;
  logic              arm_entry;

  assign key_edge  = KEY_START & ~key_prev_q;
  assign arm_entry = (state_d == ARM) && (state_q != ARM);

  always_ff @(posedge CLK or negedge NOT_RST) begin
    if (!NOT_RST) begin
      state_q    <= IDLE;
      key_prev_q <= 1'b1;
      GAMECLR    <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= KEY_START;
      GAMECLR    <= arm_entry;
    end
  end

  // ARM hold counter, restarted on every ARM entry.
  always_ff @(posedge CLK or negedge NOT_RST) begin
    if (!NOT_RST) begin
      tick_cnt_q <= 8'd0;
    end else if (arm_entry) begin
      tick_cnt_q <= 8'd0;
    end else if (state_q == ARM && state_d == ARM && TICK) begin
      tick_cnt_q <= tick_cnt_q + 8'd1;
    end
  end

  // Freeze the last live frame at the moment of collision.
  always_ff @(posedge CLK or negedge NOT_RST) begin
    if (!NOT_RST) begin
      snap_q <= '0;
    end else if (state_q == PLAY && state_d == OVER) begin
      snap_q <= PixGAME;
    end
  end

`ifdef BLINK_GAMEOVER_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_TICKS - 1);

  logic [7:0] blink_cnt_q;
  logic       blink_q;
  logic       over_entry;

  assign over_entry = (state_d == OVER) && (state_q != OVER);

  // Blink phase starts on the snapshot at each OVER entry.
  always_ff @(posedge CLK or negedge NOT_RST) begin
    if (!NOT_RST) begin
      blink_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else if (over_entry) begin
      blink_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else if (state_q == OVER && TICK) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= 8'd0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 8'd1;
      end
    end
  end
`endif

  // Next state and state-decoded outputs; STARTen low overrides everything.
  always_comb begin
    state_d = state_q;
    PHASE   = state_q;
    GAMEen  = 1'b0;
    PixOUT  = PixRST;

    if (!STARTen) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (key_edge) state_d = ARM;
        ARM:     if (TICK && tick_cnt_q == HOLD_LAST) state_d = PLAY;
        PLAY:    if (COLLIDE) state_d = OVER;
        OVER:    if (key_edge) state_d = ARM;
        default: state_d = IDLE;
      endcase
    end

    case (state_q)
      PLAY: begin
        GAMEen = 1'b1;
        PixOUT = PixGAME;
      end
      OVER: begin
`ifdef BLINK_GAMEOVER_EN
        PixOUT = blink_q ? '0 : snap_q;
`else
        PixOUT = snap_q;
`endif
      end
      default: PixOUT = PixRST;
    endcase
  end

endmodule
